ddr4_fine_sweep: RTL

//  Per-lane fine read-delay sweep engine for DDR4 PHY training; sits directly upstream of ddr4_fsm.
//  On fine_start it steps the shared delay line across all taps, samples read_ok per lane and scores each tap.
//  For each lane it tracks the widest contiguous passing window and reports it.
//  It then asserts fine_done (enough lanes usable) or fine_failed; ddr4_fsm consumes the result to centre and lock.

---
 rtl/ddr4_fine_sweep.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ddr4_fine_sweep.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : ddr4_fine_sweep                                                 |
// | Brief   : Per-lane fine read-delay sweep; finds each lane's widest window |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module ddr4_fine_sweep #(
    parameter int LANES              = 16,
    parameter int DELAY_TAPS         = 64,
    parameter int SAMPLES_PER_TAP    = 8,
    parameter int PASS_THRESHOLD     = 7,
    parameter int SETTLE_CYCLES      = 4,
    parameter int MIN_GROUP_WIDTH    = 6,
    parameter int MIN_LANES_REQUIRED = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fine_start,
    input  logic [LANES-1:0]                  read_ok,
    output logic [$clog2(DELAY_TAPS)-1:0]     sweep_tap,
    output logic                              sample_en,
    output logic                              busy,
    output logic                              fine_done,
    output logic                              fine_failed,
    output logic [LANES-1:0]                  lane_valid,
    output logic [$clog2(DELAY_TAPS)-1:0]     best_start [0:LANES-1],
    output logic [$clog2(DELAY_TAPS)-1:0]     best_end   [0:LANES-1],
    output logic [$clog2(DELAY_TAPS+1)-1:0]   best_width [0:LANES-1]
);
    localparam int TW = $clog2(DELAY_TAPS);
    localparam int WW = $clog2(DELAY_TAPS + 1);
    localparam int CW = $clog2(SAMPLES_PER_TAP + 1);
    localparam int PW = $clog2(SETTLE_CYCLES + SAMPLES_PER_TAP + 1);
    localparam int LW = $clog2(LANES + 1);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_settle = 3'd1;
    localparam logic [2:0] c_s_sample = 3'd2;
    localparam logic [2:0] c_s_eval   = 3'd3;
    localparam logic [2:0] c_s_report = 3'd4;
    localparam logic [2:0] c_s_done   = 3'd5;

    localparam logic [TW-1:0] c_last_tap    = TW'(DELAY_TAPS - 1);
    localparam logic [PW-1:0] c_settle_last = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] c_sample_last = PW'(SAMPLES_PER_TAP - 1);
    localparam logic [CW-1:0] c_pass_thr    = CW'(PASS_THRESHOLD);
    localparam logic [WW-1:0] c_min_width   = WW'(MIN_GROUP_WIDTH);
    localparam logic [LW-1:0] c_min_lanes   = LW'(MIN_LANES_REQUIRED);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_prev_start;
    logic [PW-1:0] r_phase;
    logic [CW-1:0] r_cnt       [LANES];
    logic [WW-1:0] r_run_len   [LANES];
    logic [TW-1:0] r_run_start [LANES];

    logic          w_start_edge;
    logic          w_in_sweep;
    logic          w_abort;
    logic [LANES-1:0] w_pass;
    logic [LANES-1:0] w_valid;
    logic [LW-1:0] w_valid_cnt;
    logic [WW-1:0] w_new_len   [LANES];
    logic [TW-1:0] w_new_start [LANES];

    assign w_start_edge = fine_start & ~r_prev_start;
    assign w_in_sweep   = (r_state == c_s_settle) || (r_state == c_s_sample) ||
                          (r_state == c_s_eval)   || (r_state == c_s_report);
    assign w_abort      = w_in_sweep & ~fine_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle, c_s_done: begin
                if (w_start_edge) w_next_state = c_s_settle;
            end
            c_s_settle: begin
                if (!fine_start)                 w_next_state = c_s_idle;
                else if (r_phase == c_settle_last) w_next_state = c_s_sample;
            end
            c_s_sample: begin
                if (!fine_start)                 w_next_state = c_s_idle;
                else if (r_phase == c_sample_last) w_next_state = c_s_eval;
            end
            c_s_eval: begin
                if (!fine_start)                 w_next_state = c_s_idle;
                else if (sweep_tap == c_last_tap) w_next_state = c_s_report;
                else                             w_next_state = c_s_settle;
            end
            c_s_report: begin
                if (!fine_start) w_next_state = c_s_idle;
                else             w_next_state = c_s_done;
            end
            default: w_next_state = c_s_idle;
        endcase
    end

    always_comb begin
        sample_en = (r_state == c_s_sample);
        busy      = w_in_sweep;
    end

    // Per-lane tap scoring and lane-count tally for the report step.
    always_comb begin
        w_valid_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pass[l]      = (r_cnt[l] >= c_pass_thr);
            w_new_len[l]   = r_run_len[l] + WW'(1);
            w_new_start[l] = (r_run_len[l] == '0) ? sweep_tap : r_run_start[l];
            w_valid[l]     = (best_width[l] >= c_min_width);
            w_valid_cnt    = w_valid_cnt + LW'(w_valid[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_start <= 1'b0;
            r_phase      <= '0;
            sweep_tap    <= '0;
            fine_done    <= 1'b0;
            fine_failed  <= 1'b0;
            lane_valid   <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_cnt[l]       <= '0;
                r_run_len[l]   <= '0;
                r_run_start[l] <= '0;
                best_start[l]  <= '0;
                best_end[l]    <= '0;
                best_width[l]  <= '0;
            end
        end else begin
            r_prev_start <= fine_start;
            r_phase      <= (w_next_state != r_state) ? '0 : r_phase + PW'(1);
            if ((r_state == c_s_idle || r_state == c_s_done) && w_start_edge) begin
                sweep_tap   <= '0;
                fine_done   <= 1'b0;
                fine_failed <= 1'b0;
                lane_valid  <= '0;
                for (int l = 0; l < LANES; l++) begin
                    r_cnt[l]       <= '0;
                    r_run_len[l]   <= '0;
                    r_run_start[l] <= '0;
                    best_start[l]  <= '0;
                    best_end[l]    <= '0;
                    best_width[l]  <= '0;
                end
            end else if (!w_abort) begin
                case (r_state)
                    c_s_sample: begin
                        for (int l = 0; l < LANES; l++)
                            r_cnt[l] <= r_cnt[l] + CW'(read_ok[l]);
                    end
                    c_s_eval: begin
                        for (int l = 0; l < LANES; l++) begin
                            r_cnt[l] <= '0;
                            if (w_pass[l]) begin
                                r_run_len[l]   <= w_new_len[l];
                                r_run_start[l] <= w_new_start[l];
                                // Strict compare keeps the earliest of equal windows.
                                if (w_new_len[l] > best_width[l]) begin
                                    best_start[l] <= w_new_start[l];
                                    best_end[l]   <= sweep_tap;
                                    best_width[l] <= w_new_len[l];
                                end
                            end else begin
                                r_run_len[l] <= '0;
                            end
                        end
                        if (sweep_tap != c_last_tap) sweep_tap <= sweep_tap + TW'(1);
                    end
                    c_s_report: begin
                        lane_valid  <= w_valid;
                        fine_done   <= (w_valid_cnt >= c_min_lanes);
                        fine_failed <= (w_valid_cnt <  c_min_lanes);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
